// File: rtl/mdv_wr.sv
// mdv_wr: microdrive tape write engine that paces bytes from a one-deep holding register into an image RAM
// Ports:
//   clk, reset_n         system clock, synchronous active-low reset
//   ce                   tape pacing clock enable; BYTE_TICKS enables make one byte slot
//   sel, wr_gate, erase  drive select and mctrl write-gate / erase-head controls
//   start_pos, img_len   head address sampled at burst start, image length (wrap point)
//   tx_wr, tx_data       CPU write strobe and byte into the holding register
//   tx_empty             holding register empty
//   busy                 burst (WRITE or ERASE) in progress
//   ram_addr/dout/we     image RAM write port, one clk strobe per slot
//   underrun, overrun    sticky error flags, cleared at burst start
//   csum                 running checksum of data bytes; only built with MDV_WR_CSUM_EN, else 0
module mdv_wr #(
  parameter int BYTE_TICKS = 6,
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          sel,
  input  logic          wr_gate,
  input  logic          erase,
  input  logic [AW-1:0] start_pos,
  input  logic [AW-1:0] img_len,
  input  logic          tx_wr,
  input  logic [7:0]    tx_data,
  output logic          tx_empty,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_dout,
  output logic          ram_we,
  output logic          underrun,
  output logic          overrun,
  output logic [15:0]   csum
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ERASE = 2'd1, S_WRITE = 2'd2;
  localparam logic [7:0] LAST_TICK = 8'(BYTE_TICKS - 1);
  logic [1:0]    r_state;
  logic [7:0]    r_tick, r_hold, r_dout;
  logic [AW-1:0] r_addr, r_ram_addr;
  logic          r_full, r_seen, r_under, r_over, r_we, r_prev_gate;
  logic          w_gate, w_erase_req, w_start_wr, w_start_er, w_start, w_stay;
  logic          w_slot, w_wslot, w_consume, w_load;
  logic [AW-1:0] w_next_addr;
  assign w_gate      = sel && wr_gate;
  assign w_erase_req = sel && erase && !wr_gate;
  // a write burst needs a fresh gate edge, so a gate held through reset cannot restart one
  assign w_start_wr  = (r_state == S_IDLE) && w_gate && !r_prev_gate;
  assign w_start_er  = (r_state == S_IDLE) && !w_start_wr && w_erase_req;
  assign w_start     = w_start_wr || w_start_er;
  assign w_stay      = ((r_state == S_WRITE) && w_gate) || ((r_state == S_ERASE) && w_erase_req);
  assign w_slot      = w_stay && ce && (r_tick == LAST_TICK);
  assign w_wslot     = w_slot && (r_state == S_WRITE);
  assign w_consume   = w_wslot && r_full;
  // a consuming slot frees the register on the same clk, so a coincident tx_wr is accepted
  assign w_load      = tx_wr && (!r_full || w_consume);
  assign w_next_addr = (r_addr == img_len - AW'(1)) ? '0 : r_addr + AW'(1);
  always_ff @(posedge clk) begin
    r_prev_gate <= w_gate;
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_dout     <= '0;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_seen     <= 1'b0;
      r_under    <= 1'b0;
      r_over     <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      r_state <= w_start_wr ? S_WRITE : w_start_er ? S_ERASE : w_stay ? r_state : S_IDLE;
      r_we    <= w_slot;
      if (w_start) begin
        r_addr  <= start_pos;
        r_tick  <= '0;
        r_seen  <= 1'b0;
        r_under <= 1'b0;
        r_over  <= 1'b0;
      end else if (w_stay && ce) begin
        r_tick <= w_slot ? '0 : r_tick + 8'd1;
      end
      if (w_slot) begin
        r_ram_addr <= r_addr;
        r_dout     <= w_consume ? r_hold : 8'h00;
        r_addr     <= w_next_addr;
      end
      if (w_consume) r_seen <= 1'b1;
      if (w_wslot && !r_full && r_seen) r_under <= 1'b1;
      if (tx_wr && !w_load) r_over <= 1'b1;
      if (w_load) r_hold <= tx_data;
      r_full <= w_load || (r_full && !w_consume);
    end
  end
`ifdef MDV_WR_CSUM_EN
  logic [15:0] r_csum;
  always_ff @(posedge clk) begin
    if (!reset_n) r_csum <= '0;
    else if (w_start) r_csum <= 16'h0F0F;
    else if (w_consume) r_csum <= r_csum + {8'h00, r_hold};
  end
  assign csum = r_csum;
`else
  assign csum = 16'h0000;
`endif
  assign tx_empty = !r_full;
  assign busy     = (r_state != S_IDLE);
  assign ram_addr = r_ram_addr;
  assign ram_dout = r_dout;
  assign ram_we   = r_we;
  assign underrun = r_under;
  assign overrun  = r_over;
endmodule

// File: tb/tb_mdv_wr.sv
// tb_mdv_wr: directed and randomized bench for mdv_wr against a burst-level behavioural model
module tb_mdv_wr;
  localparam int BT = 6;
  localparam int AW = 17;
  logic          clk = 1'b0;
  logic          reset_n, ce, sel, wr_gate, erase, tx_wr;
  logic [AW-1:0] start_pos, img_len;
  logic [7:0]    tx_data;
  logic          tx_empty, busy, ram_we, underrun, overrun;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [15:0]   csum;
  int total = 0;
  int bad = 0;
  int dw_a[$], dw_d[$], mw_a[$], mw_d[$];
  int   m_mode = 0;
  int   m_ce = 0;
  int   m_addr = 0;
  bit   m_prev = 0, m_full = 0, m_seen = 0, m_under = 0, m_over = 0;
  int   m_hold = 0;
  bit   e_we = 0;
  int   e_addr = 0, e_dout = 0;
  int   e_csum = 0;
  mdv_wr #(.BYTE_TICKS(BT), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .sel(sel), .wr_gate(wr_gate), .erase(erase),
    .start_pos(start_pos), .img_len(img_len), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_empty(tx_empty), .busy(busy), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_we(ram_we), .underrun(underrun), .overrun(overrun), .csum(csum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  // Behavioural model: a burst is a mode plus a count of ce clks since it began;
  // every BT-th ce clk is a byte slot. The holding register is a byte plus a full flag.
  always @(posedge clk) begin
    bit g, er, slot, cons;
    g = sel && wr_gate;
    er = sel && erase && !wr_gate;
    slot = 0;
    if (!reset_n) begin
      m_mode = 0; m_full = 0; m_under = 0; m_over = 0;
      e_we = 0; e_addr = 0; e_dout = 0; e_csum = 0;
    end else begin
      e_we = 0;
      if (m_mode == 0) begin
        if (g && !m_prev) m_mode = 1;
        else if (er) m_mode = 2;
        if (m_mode != 0) begin
          m_addr = int'(start_pos); m_ce = 0; m_under = 0; m_over = 0; m_seen = 0; e_csum = 'h0F0F;
        end
      end else if ((m_mode == 1 && g) || (m_mode == 2 && er)) begin
        if (ce) begin
          m_ce++;
          slot = (m_ce % BT) == 0;
        end
      end else m_mode = 0;
      cons = slot && m_mode == 1 && m_full;
      if (slot) begin
        e_we = 1; e_addr = m_addr; e_dout = cons ? m_hold : 0;
        m_addr = (m_addr + 1) % int'(img_len);
      end
      if (cons) begin
        m_seen = 1;
        e_csum = (e_csum + m_hold) % 65536;
      end else if (slot && m_mode == 1 && m_seen) m_under = 1;
      if (tx_wr) begin
        if (!m_full || cons) begin m_hold = int'(tx_data); m_full = 1; end
        else m_over = 1;
      end else if (cons) m_full = 0;
    end
    m_prev = g;
  end
  always @(negedge clk) begin
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_dout", ram_dout, e_dout);
    chk("tx_empty", tx_empty, !m_full);
    chk("busy", busy, m_mode != 0);
    chk("underrun", underrun, m_under);
    chk("overrun", overrun, m_over);
`ifdef MDV_WR_CSUM_EN
    chk("csum", csum, e_csum);
`else
    chk("csum", csum, 0);
`endif
    if (ram_we) begin dw_a.push_back(int'(ram_addr)); dw_d.push_back(int'(ram_dout)); end
    if (e_we) begin mw_a.push_back(e_addr); mw_d.push_back(e_dout); end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clr();
    dw_a.delete(); dw_d.delete(); mw_a.delete(); mw_d.delete();
  endtask
  task automatic wait_wr(input int n, input string nm);
    int i = 0;
    while (dw_a.size() < n && i < 200) begin cyc(1); i++; end
    chk(nm, dw_a.size() >= n, 1);
  endtask
  task automatic tx(input int d);
    tx_wr = 1; tx_data = 8'(d); cyc(1); tx_wr = 0;
  endtask
  initial begin
    reset_n = 0; ce = 1; sel = 0; wr_gate = 0; erase = 0; tx_wr = 0; tx_data = 0;
    start_pos = 0; img_len = 1000;
    cyc(3);
    chk("rst tx_empty", tx_empty, 1);
    chk("rst busy", busy, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst csum", csum, 0);
    chk("rst flags", {underrun, overrun}, 0);
    reset_n = 1; cyc(2);
    // basic write
    clr(); start_pos = 100; sel = 1; wr_gate = 1; cyc(1);
    tx('hA5);
    wait_wr(1, "A wait");
    chk("A addr", at(dw_a, 0), 100);
    chk("A data", at(dw_d, 0), 'hA5);
    chk("A model addr", at(mw_a, 0), 100);
    chk("A model data", at(mw_d, 0), 'hA5);
    chk("A tx_empty", tx_empty, 1);
`ifdef MDV_WR_CSUM_EN
    chk("A csum", csum, 'h0FB4);
    chk("A model csum", e_csum, 'h0FB4);
`else
    chk("A csum", csum, 0);
`endif
    sel = 0; wr_gate = 0; cyc(2);
    // wrap-around
    img_len = 4; start_pos = 3; tx('h21);
    clr(); sel = 1; wr_gate = 1;
    wait_wr(1, "B wait1");
    tx('h22);
    wait_wr(2, "B wait2");
    chk("B addr0", at(dw_a, 0), 3);
    chk("B data0", at(dw_d, 0), 'h21);
    chk("B addr1", at(dw_a, 1), 0);
    chk("B data1", at(dw_d, 1), 'h22);
    chk("B model addr1", at(mw_a, 1), 0);
    sel = 0; wr_gate = 0; cyc(2);
    // underrun
    img_len = 1000; start_pos = 10; tx('h11);
    clr(); sel = 1; wr_gate = 1;
    wait_wr(2, "C wait");
    chk("C data0", at(dw_d, 0), 'h11);
    chk("C data1", at(dw_d, 1), 0);
    chk("C underrun", underrun, 1);
    chk("C model underrun", m_under, 1);
    wr_gate = 0; cyc(2);
    wr_gate = 1; cyc(1);
    chk("C underrun cleared", underrun, 0);
    chk("C busy", busy, 1);
    sel = 0; wr_gate = 0; cyc(2);
    // overrun
    start_pos = 200; clr(); sel = 1; wr_gate = 1; cyc(1);
    tx('h31); tx('h32); tx('h33);
    chk("D overrun", overrun, 1);
    chk("D tx_empty", tx_empty, 0);
    wait_wr(1, "D wait");
    chk("D data0", at(dw_d, 0), 'h31);
    chk("D overrun held", overrun, 1);
    sel = 0; wr_gate = 0; cyc(2);
    // tx_wr on the consuming clk
    ce = 0; start_pos = 300; clr(); sel = 1; wr_gate = 1; cyc(1);
    tx('h41);
    ce = 1; cyc(BT - 1);
    tx('h42);
    ce = 0;
    chk("D2 ram_we", ram_we, 1);
    chk("D2 dout", ram_dout, 'h41);
    chk("D2 tx_empty", tx_empty, 0);
    chk("D2 overrun", overrun, 0);
    ce = 1;
    wait_wr(2, "D2 wait");
    chk("D2 data1", at(dw_d, 1), 'h42);
    chk("D2 overrun end", overrun, 0);
    sel = 0; wr_gate = 0; cyc(2);
    // erase
    tx('h55);
    clr(); start_pos = 500; sel = 1; erase = 1;
    wait_wr(3, "E wait");
    erase = 0;
    chk("E addr0", at(dw_a, 0), 500);
    chk("E addr1", at(dw_a, 1), 501);
    chk("E addr2", at(dw_a, 2), 502);
    chk("E data", at(dw_d, 0) | at(dw_d, 1) | at(dw_d, 2), 0);
    chk("E tx_empty", tx_empty, 0);
    cyc(2);
    // reset mid-burst
    clr(); wr_gate = 1; cyc(3);
    reset_n = 0; cyc(1); reset_n = 1;
    chk("F busy", busy, 0);
    chk("F tx_empty", tx_empty, 1);
    chk("F ram_we", ram_we, 0);
    cyc(20);
    chk("F no write", dw_a.size(), 0);
    wr_gate = 0; cyc(2);
    wr_gate = 1;
    wait_wr(1, "F wait");
    chk("F data0", at(dw_d, 0), 0);
    sel = 0; wr_gate = 0; cyc(2);
    // randomized traffic
    img_len = 7; sel = 1;
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) wr_gate = ~wr_gate;
      if ($urandom_range(0, 49) == 0) erase = ~erase;
      if ($urandom_range(0, 59) == 0) sel = ~sel;
      tx_wr = ($urandom_range(0, 5) == 0);
      tx_data = 8'($urandom);
      reset_n = ($urandom_range(0, 399) != 0);
      start_pos = AW'($urandom_range(0, 6));
      cyc(1);
    end
    reset_n = 1; tx_wr = 0; cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
